// File: rtl/mmp_iddmm_task_seq.sv
// Task sequencer for the IDDMM core: one-shot/periodic launch, per-task watchdog,
// XOR-folded result signature checked against a golden value, saturating statistics.
module mmp_iddmm_task_seq #(
  parameter int unsigned RES_W       = 128,
  parameter int unsigned PERIOD_CYC  = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic             one_shot,
  input  logic [RES_W-1:0] golden_sig,
  output logic             task_req,
  input  logic             task_end,
  input  logic             task_grant,
  input  logic [RES_W-1:0] task_res,
  output logic             busy,
  output logic [RES_W-1:0] sig,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] tmo_cnt,
  output logic [LED_W-1:0] led
);

  localparam int unsigned MAX_CYC = (PERIOD_CYC > TIMEOUT_CYC) ? PERIOD_CYC : TIMEOUT_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(PERIOD_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_CHK} state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             tmo_hit;
  logic             tmo_q;
  logic [RES_W-1:0] acc;
  logic             last_pass, last_fail, last_tmo;

  always_comb begin
    state_n = state;
    timer_n = timer;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (one_shot) begin
          state_n = S_REQ;
          timer_n = '0;
        end else if (run_en) begin
          state_n = S_WAIT;
          timer_n = '0;
        end
      end
      S_WAIT: begin
        if (!run_en) begin
          state_n = S_IDLE;
        end else if (timer == PER_LAST) begin
          state_n = S_REQ;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_REQ: begin
        // task_end wins over a watchdog expiry in the same cycle
        if (task_end) begin
          state_n = S_CHK;
        end else if ((TIMEOUT_CYC != 0) && (timer == TMO_LAST)) begin
          state_n = S_CHK;
          tmo_hit = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_CHK: begin
        state_n = run_en ? S_WAIT : S_IDLE;
        timer_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      task_req <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      task_req <= (state_n == S_REQ);
      if (state == S_REQ) tmo_q <= tmo_hit;
    end
  end

  // Accumulator is held clear outside REQ, so REQ entry always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (state == S_REQ) begin
      if (task_grant) acc <= acc ^ task_res;
    end else if (state != S_CHK) begin
      acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      tmo_cnt   <= '0;
      last_pass <= 1'b0;
      last_fail <= 1'b0;
      last_tmo  <= 1'b0;
    end else if (state == S_CHK) begin
      if (tmo_q) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        last_pass <= 1'b0;
        last_fail <= 1'b0;
        last_tmo  <= 1'b1;
      end else begin
        sig      <= acc;
        last_tmo <= 1'b0;
        if (acc == golden_sig) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
          last_pass <= 1'b1;
          last_fail <= 1'b0;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          last_pass <= 1'b0;
          last_fail <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign led  = {sig[LED_W-4:0], last_tmo, last_fail, last_pass};

endmodule

// File: tb/tb_mmp_iddmm_task_seq.sv
// Scoreboard bench for mmp_iddmm_task_seq: driver pushes per-task expectations,
// a monitor pops them when task_req falls and checks the results one cycle later.
module tb_mmp_iddmm_task_seq;
  localparam int unsigned RES_W = 128;
  localparam int unsigned PER   = 10;
  localparam int unsigned TMO   = 20;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned LED_W = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, run_en = 1'b0, one_shot = 1'b0;
  logic task_end = 1'b0, task_grant = 1'b0;
  logic [RES_W-1:0] golden_sig = '0, task_res = '0;
  logic task_req, busy;
  logic [RES_W-1:0] sig;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, tmo_cnt;
  logic [LED_W-1:0] led;

  mmp_iddmm_task_seq #(
    .RES_W(RES_W), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .one_shot(one_shot),
    .golden_sig(golden_sig), .task_req(task_req), .task_end(task_end),
    .task_grant(task_grant), .task_res(task_res), .busy(busy), .sig(sig),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt), .led(led)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               len;
    logic [RES_W-1:0] sig;
    int               p, f, t;
    logic [LED_W-1:0] led;
  } exp_t;

  exp_t q[$];
  int m_p = 0, m_f = 0, m_t = 0;
  logic [RES_W-1:0] m_sig = '0;
  logic [RES_W-1:0] bd[32];
  bit bg[32];

  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int c);
    return (c < CMAX) ? c + 1 : CMAX;
  endfunction

  // Monitor
  exp_t cur;
  bit prev = 0, pend = 0;
  int hi = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 0; pend = 0; hi = 0;
    end else begin
      if (pend) begin
        chk("sig", sig, cur.sig);
        chk("pass_cnt", pass_cnt, cur.p);
        chk("fail_cnt", fail_cnt, cur.f);
        chk("tmo_cnt", tmo_cnt, cur.t);
        chk("led", led, cur.led);
        pend = 0;
      end
      if (prev && !task_req) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_task: task_req pulse of %0d cycles with no task launched", hi);
        end else begin
          cur = q.pop_front();
          chk("req_len", hi, cur.len);
          pend = 1;
        end
        hi = 0;
      end
      if (task_req) hi++;
      prev = task_req;
    end
  end

  task automatic clear_beats();
    for (int i = 0; i < 32; i++) begin bg[i] = 0; bd[i] = '0; end
  endtask

  task automatic rand_beats();
    for (int i = 0; i < 32; i++) begin
      bg[i] = 1'($urandom_range(0, 1));
      bd[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic launch(output bit ok);
    ok = 0;
    one_shot = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (task_req) begin ok = 1; break; end
    end
    one_shot = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL launch: task_req=0 expected 1 within 5 cycles of one_shot");
    end
  endtask

  // Entered in the first cycle of task_req high. match=1 picks golden equal to the expected fold.
  task automatic do_task(input int end_k, input logic [RES_W-1:0] gold, input bit match, input bit mid_os);
    int len;
    bit tmo;
    logic [RES_W-1:0] a;
    exp_t e;
    tmo = (end_k >= int'(TMO));
    len = tmo ? int'(TMO) : end_k + 1;
    a = '0;
    for (int k = 0; k < len; k++) if (bg[k]) a = a ^ bd[k];
    golden_sig = match ? a : gold;
    if (tmo) m_t = sat(m_t);
    else begin
      m_sig = a;
      if (a == golden_sig) m_p = sat(m_p); else m_f = sat(m_f);
    end
    e.len = len; e.sig = m_sig; e.p = m_p; e.f = m_f; e.t = m_t;
    e.led = {m_sig[LED_W-4:0], tmo, !tmo && (a != golden_sig), !tmo && (a == golden_sig)};
    q.push_back(e);
    for (int k = 0; k <= len + 1; k++) begin
      task_grant = bg[k];
      task_res   = bd[k];
      task_end   = (k == end_k);
      one_shot   = mid_os && (k == 0);
      @(posedge clk); #1;
    end
    task_grant = 1'b0; task_end = 1'b0; one_shot = 1'b0; task_res = '0;
  endtask

  task automatic one_task(input int end_k, input logic [RES_W-1:0] gold, input bit match, input bit mid_os);
    bit ok;
    launch(ok);
    if (ok) begin
      do_task(end_k, gold, match, mid_os);
      chk("idle_after_task", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    bit ok;
    int last, idle_bad;
    #2;
    chk("rst_task_req", task_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sig", sig, 0);
    chk("rst_led", led, 0);
    chk("rst_pass", pass_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed: A5 ^ 0F = AA
    clear_beats();
    bg[0] = 1; bd[0] = 128'hA5;
    bg[1] = 1; bd[1] = 128'h0F;
    one_task(2, 128'hAA, 0, 0);
    one_task(2, 128'h0, 0, 0);
    clear_beats();
    bg[3] = 1; bd[3] = 128'h1234;
    one_task(int'(TMO) + 3, 128'h0, 0, 0);
    clear_beats();
    bg[0] = 1; bd[0] = 128'h5;
    bg[3] = 1; bd[3] = 128'h30;
    bg[4] = 1; bd[4] = 128'hFF;
    one_task(3, 128'h0, 1, 1);
    rand_beats();
    one_task(int'(TMO) - 1, 128'h0, 1, 0);

    for (int n = 0; n < 40; n++) begin
      rand_beats();
      one_task(int'($urandom_range(0, TMO + 5)), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a task
    launch(ok);
    task_grant = 1'b1; task_res = 128'hDEAD;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_task_req", task_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pass", pass_cnt, 0);
    chk("midrst_fail", fail_cnt, 0);
    chk("midrst_tmo", tmo_cnt, 0);
    chk("midrst_led", led, 0);
    task_grant = 1'b0; task_res = '0;
    q.delete();
    m_p = 0; m_f = 0; m_t = 0; m_sig = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy || task_req) idle_bad++;
    end
    chk("idle_after_reset", idle_bad, 0);

    // Periodic mode: core ends 5 cycles after request
    run_en = 1'b1;
    last = 0;
    for (int r = 0; r < 3; r++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        if (task_req) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      if (!ok) begin
        tests++; fails++;
        $display("FAIL periodic_launch: task_req=0 expected 1 within 40 cycles");
        break;
      end
      if (r > 0) chk("period", cyc - last, PER + 7);
      last = cyc;
      rand_beats();
      do_task(5, '0, 1, 0);
    end
    run_en = 1'b0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    chk("periodic_stop_idle", busy, 0);
    chk("periodic_pass_cnt", pass_cnt, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
